// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                program loader (FSM state encoding, word geometry).
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    localparam int DEFAULT_INSTRUCT_MEM_SIZE = 1024;
    localparam int BYTES_PER_WORD            = 4;
    localparam int MAX_WORDS                 = DEFAULT_INSTRUCT_MEM_SIZE / BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    // Word capacity of a memory of the given byte size, as an unsigned
    // 32-bit value so it can be compared directly against the header.
    function automatic logic [31:0] max_words(input int mem_size);
        return 32'(mem_size / BYTES_PER_WORD);
    endfunction

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_byte_packer
//  Description : Packs an MSB-first byte stream into 32-bit words. Used for
//                both the length header and the instruction words.
//  Ports       : clk, reset_n      clock, async active-low reset
//                i_clear           discard any partially assembled word
//                i_accept          a byte is consumed this cycle
//                i_byte            byte being consumed
//                o_word_valid      this byte completes a word
//                o_word            completed word (valid with o_word_valid)
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] C_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    // Only the three older bytes are stored; the fourth is taken straight
    // from the input so the word is available on the completing cycle.
    logic [23:0] sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (i_clear) begin
            cnt_d = 2'd0;
        end else if (i_accept) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {sr_q[15:0], i_byte};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign o_word_valid = i_accept && !i_clear && (cnt_q == C_LAST_BYTE);
    assign o_word       = {sr_q, i_byte};

endmodule : imem_loader_byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Program loader. Receives a byte stream (4-byte word-count
//                header, then instruction words), writes each word into
//                instruction RAM at word-aligned addresses and holds the CPU
//                in reset until the image is loaded.
//  Ports       : clk, reset_n      clock, async active-low reset
//                start             pulse that begins a load
//                byte_in/valid/ready  byte stream handshake
//                wr_en/addr/data   instruction RAM write port
//                cpu_hold          CPU held in reset while high
//                done / error      load finished / header too large
//                words_loaded      words written in the current load
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTRUCT_MEM_SIZE = DEFAULT_INSTRUCT_MEM_SIZE,
    parameter int ADDR_W            = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam logic [31:0] C_MAX_WORDS = max_words(INSTRUCT_MEM_SIZE);

    state_e      state_q, state_d;
    logic [31:0] length_q, length_d;
    logic [31:0] data_q, data_d;
    logic [15:0] words_q, words_d;

    logic        w_accept;
    logic        w_clear;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic [15:0] w_words_inc;

    assign byte_ready = (state_q == LEN) || (state_q == DATA);
    assign w_accept   = byte_valid && byte_ready;
    assign w_words_inc = words_q + 16'd1;

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_byte       (byte_in),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        data_d   = data_q;
        words_d  = words_q;
        w_clear  = 1'b0;
        case (state_q)
            // A new load may begin from any idle-like state; the count is
            // reset here so done/error/words_loaded all clear together.
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    words_d = 16'd0;
                    w_clear = 1'b1;
                end
            end
            LEN: begin
                if (w_word_valid) begin
                    length_d = w_word;
                    if (w_word == 32'd0) begin
                        state_d = DONE;
                    end else if (w_word > C_MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_valid) begin
                    data_d  = w_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = w_words_inc;
                if ({16'd0, w_words_inc} == length_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            length_q <= 32'd0;
            data_q   <= 32'd0;
            words_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            data_q   <= data_d;
            words_q  <= words_d;
        end
    end

    assign wr_en        = (state_q == WRITE);
    assign wr_addr      = ADDR_W'({words_q, 2'b00});
    assign wr_data      = data_q;
    assign cpu_hold     = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign words_loaded = words_q;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking testbench for imem_loader with a queue-based
//                reference model of the expected RAM writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    typedef logic [31:0] wq_t[$];
    typedef logic [7:0]  bq_t[$];

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];

    always #5 clk = ~clk;

    imem_loader #(.INSTRUCT_MEM_SIZE(1024), .ADDR_W(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Write monitor: logs every RAM write and checks the per-write rules.
    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_ready: byte_ready=%b required 0 during write", byte_ready);
            end
            checks++;
            if (wr_addr[1:0] !== 2'b00 || wr_addr + 64'd3 >= 64'd1024) begin
                errors++;
                $display("FAIL write_addr_range: addr=0x%0h not aligned/in range", wr_addr);
            end
        end
    end

    // Reference model: header word count n, then n words MSB first.
    function automatic wq_t model_words(input bq_t b, input int n);
        wq_t w;
        for (int i = 0; i < n; i++) begin
            w.push_back(32'(b[4*i]) * 32'h0100_0000 + 32'(b[4*i+1]) * 32'h0001_0000
                      + 32'(b[4*i+2]) * 32'h0000_0100 + 32'(b[4*i+3]));
        end
        return w;
    endfunction

    function automatic bq_t header_bytes(input logic [31:0] n);
        bq_t q;
        q.push_back(8'(n / 32'h0100_0000));
        q.push_back(8'((n / 32'h0001_0000) % 256));
        q.push_back(8'((n / 32'h0000_0100) % 256));
        q.push_back(8'(n % 256));
        return q;
    endfunction

    function automatic bq_t random_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input bq_t b, input bit rand_valid, input bit inject_start);
        int  i;
        int  guard;
        bit  acc;
        i = 0;
        guard = 0;
        while (i < b.size() && guard < 20000) begin
            byte_in    = b[i];
            byte_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = inject_start ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        checks++;
        if (i < b.size()) begin
            errors++;
            $display("FAIL send_timeout: sent %0d bytes required %0d", i, b.size());
        end
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_end_timeout: done=%b error=%b never asserted", tag, done, error);
        end
        checks++;
        if (done === 1'b1 && error === 1'b1) begin
            errors++;
            $display("FAIL %s_done_and_error: both high", tag);
        end
    endtask

    task automatic check_writes(input string tag, input wq_t exp);
        checks++;
        if (got_data.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_write_count: got %0d required %0d", tag, got_data.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== 64'(4 * i) || got_data[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_write%0d: got addr=0x%0h data=0x%08h required addr=0x%0h data=0x%08h",
                         tag, i, got_addr[i], got_data[i], 4 * i, exp[i]);
            end
        end
    endtask

    task automatic run_load(input string tag, input int n, input bit rand_valid, input bit inject);
        bq_t d;
        d = random_bytes(4 * n);
        clear_log();
        pulse_start();
        send_bytes(header_bytes(32'(n)), rand_valid, 1'b0);
        send_bytes(d, rand_valid, inject);
        wait_end(tag);
        check_writes(tag, model_words(d, n));
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || words_loaded !== 16'(n)) begin
            errors++;
            $display("FAIL %s_status: done=%b error=%b hold=%b words=%0d required 1 0 0 %0d",
                     tag, done, error, cpu_hold, words_loaded, n);
        end
    endtask

    task automatic test_reset();
        bq_t hdr;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                clear_log();
                pulse_start();
                hdr = header_bytes(32'd2);
                hdr.push_back(8'hAA);
                hdr.push_back(8'hBB);
                send_bytes(hdr, 1'b0, 1'b0);
                #2 reset_n = 1'b0;
                #1;
            end
            checks++;
            if (byte_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 64'd0 || wr_data !== 32'd0 ||
                cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
                errors++;
                $display("FAIL reset_values_ph%0d: ready=%b wr_en=%b addr=%0h data=%0h hold=%b done=%b err=%b words=%0d",
                         ph, byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, words_loaded);
            end
            @(posedge clk); #1;
            reset_n = 1'b1;
        end
        checks++;
        if (got_data.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes required 0", got_data.size());
        end
        run_load("after_reset", 1, 1'b0, 1'b0);
    endtask

    task automatic test_two_words();
        bq_t d;
        d = '{8'h91, 8'h00, 8'h04, 8'h21, 8'hF8, 8'h00, 8'h00, 8'hE0};
        clear_log();
        pulse_start();
        send_bytes(header_bytes(32'd2), 1'b0, 1'b0);
        send_bytes(d, 1'b0, 1'b0);
        wait_end("two_words");
        check_writes("two_words", '{32'h9100_0421, 32'hF800_00E0});
        checks++;
        if (got_cyc.size() == 2 && got_cyc[1] - got_cyc[0] !== 5) begin
            errors++;
            $display("FAIL two_words_spacing: got %0d cycles required 5", got_cyc[1] - got_cyc[0]);
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd2) begin
            errors++;
            $display("FAIL two_words_status: done=%b hold=%b words=%0d required 1 0 2", done, cpu_hold, words_loaded);
        end
    endtask

    task automatic test_error();
        clear_log();
        pulse_start();
        send_bytes(header_bytes(32'd257), 1'b0, 1'b0);
        wait_end("err");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || got_data.size() !== 0) begin
            errors++;
            $display("FAIL err_status: error=%b hold=%b done=%b writes=%0d required 1 1 0 0",
                     error, cpu_hold, done, got_data.size());
        end
        run_load("err_recover", 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        send_bytes(header_bytes(32'd0), 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b error=%b hold=%b required 1 0 0", done, error, cpu_hold);
        end
        @(posedge clk); #1;
        checks++;
        if (got_data.size() !== 0 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL zero_len_writes: writes=%0d words=%0d required 0 0", got_data.size(), words_loaded);
        end
    endtask

    task automatic test_random_valid();
        run_load("rand_valid", 3, 1'b1, 1'b0);
    endtask

    task automatic test_full_mem();
        run_load("full_mem", 256, 1'b0, 1'b1);
        checks++;
        if (got_addr.size() == 0 || got_addr[got_addr.size()-1] !== 64'h3FC) begin
            errors++;
            $display("FAIL full_mem_last_addr: got 0x%0h required 0x3fc",
                     got_addr.size() == 0 ? 64'd0 : got_addr[got_addr.size()-1]);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_two_words();
        test_error();
        test_zero_len();
        test_random_valid();
        test_random_valid();
        test_full_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write-side counterpart of the read-only instruction memory.
- Receives a byte stream over a valid/ready handshake. The stream is a 4-byte word-count header followed by instruction words.
- Assembles each group of 4 bytes into a 32-bit instruction and writes it word-aligned into instruction RAM.
- Holds the CPU in reset until the image is fully loaded. Sits between the host/debug link and the instruction RAM write port.

Parameters:
- INSTRUCT_MEM_SIZE, 1024: instruction memory size in bytes. Must be a power of two and > 4. Maximum word count is INSTRUCT_MEM_SIZE/4.
- ADDR_W, 64: width of the byte address driven to memory.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_W  byte address, always word-aligned (bits [1:0] = 0).
- wr_data  out  32  instruction word.
- cpu_hold  out  1  CPU held in reset while high.
- done  out  1  load completed successfully.
- error  out  1  header word count exceeds memory capacity.
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset (asynchronous, reset_n=0) drives the following, and applies even mid-load; any partial word is discarded:
  - state=IDLE
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - cpu_hold=1, done=0, error=0, words_loaded=0
- Byte accepted on a rising edge iff byte_valid && byte_ready. Bytes arrive MSB first, so the first byte lands in bits [31:24].
- byte_ready=1 only in states LEN and DATA.
- States:
  - IDLE: wait for start, then go to LEN.
  - LEN: accept 4 bytes into a 32-bit length register.
    - length==0 → DONE.
    - length > INSTRUCT_MEM_SIZE/4 → ERR.
    - otherwise → DATA.
  - DATA: accept 4 bytes into a shift register; on the 4th accepted byte go to WRITE.
  - WRITE: exactly one cycle.
    - wr_en=1, wr_addr=words_loaded*4, wr_data=assembled word, byte_ready=0.
    - words_loaded increments at the end of this cycle.
    - If the new count == length → DONE, else → DATA.
  - DONE: done=1, cpu_hold=0. start → LEN, which clears done and words_loaded and sets cpu_hold=1.
  - ERR: error=1, cpu_hold=1, no writes. start → LEN, which clears error.
- cpu_hold=1 in every state except DONE.
- start is ignored in LEN, DATA and WRITE; a load cannot be restarted except by reset.
- Latency: wr_en rises the cycle after the 4th byte of a word is accepted. Peak throughput is 1 byte/cycle with one bubble per word, i.e. 5 cycles per word.
- byte_valid low mid-word stalls the byte counter with no timeout; the partial word is kept.
- Invariants:
  - wr_addr + 3 < INSTRUCT_MEM_SIZE is always true when wr_en=1.
  - wr_addr[1:0] is always 0.
- Length comparison is unsigned 32-bit. wr_addr is zero-extended to ADDR_W.
- done and error are never high simultaneously.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum typedef (IDLE, LEN, DATA, WRITE, DONE, ERR);
  - localparam MAX_WORDS = INSTRUCT_MEM_SIZE/4;
  - localparam BYTES_PER_WORD = 4.
- One natural sub-module: byte_packer. It contains the 2-bit byte counter and 32-bit shift register, and emits word_valid plus word. It is reused for both the length header and the data words.

Test Plan:
1. Reset mid-DATA (2 bytes of a word accepted), then reset_n=0 → all outputs at reset values immediately (asynchronously), no wr_en. A fresh load afterwards writes its first word to addr 0.
2. start, header 00 00 00 02, bytes 91 00 04 21 | F8 00 00 E0 at full rate → wr_en pulses:
   - addr 0, data 0x91000421;
   - addr 4, data 0xF80000E0, 5 cycles later.
   Then done=1, cpu_hold=0, words_loaded=2.
3. Header 00 00 01 01 (257 > 256 words) → ERR: error=1, cpu_hold=1, no wr_en. A second start followed by header 00 00 00 01 and one word → done=1, error=0.
4. Header 00 00 00 00 → DONE with zero writes; done=1 the cycle after the 4th header byte.
5. byte_valid toggled randomly during a 3-word load → identical addresses 0, 4, 8 and the same data as a full-rate load. byte_ready=0 in every WRITE cycle; no byte is lost or duplicated.
6. Header 00 00 01 00 (256 words) → last write at addr 1020 (0x3FC), done=1. start pulses asserted during DATA have no effect.
